// File: rtl/gear_button_conditioner.sv
// Gear selector front end: two raw push-buttons are synchronised and debounced,
// then turned into single-cycle gear_up/gear_down pulses with auto-repeat and up+down lockout.
module gear_button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int HOLD_CYCLES     = 25000000,
    parameter int REPEAT_CYCLES   = 10000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_up_raw,
    input  logic btn_down_raw,
    output logic gear_up,
    output logic gear_down,
    output logic up_level,
    output logic down_level,
    output logic conflict
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [31:0]      HOLD_LOAD   = 32'(HOLD_CYCLES - 1);
    localparam logic [31:0]      REPEAT_LOAD = 32'(REPEAT_CYCLES - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PRESSED = 2'd1;
    localparam logic [1:0] ST_REPEAT  = 2'd2;
    localparam logic [1:0] ST_LOCKED  = 2'd3;

    // Channel index 0 is the up button, index 1 the down button.
    logic [1:0]       raw_s;
    logic [1:0]       sync1_r;
    logic [1:0]       sync2_r;
    logic [1:0]       stable_r;
    logic [1:0]       stable_next_s;
    logic [CNT_W-1:0] db_cnt_r      [2];
    logic [CNT_W-1:0] db_cnt_next_s [2];
    logic [1:0]       state_r       [2];
    logic [1:0]       state_next_s  [2];
    logic [31:0]      timer_r       [2];
    logic [31:0]      timer_next_s  [2];
    logic [1:0]       pulse_s;
    logic             conflict_s;
    logic             gear_up_r;
    logic             gear_down_r;
    logic             conflict_r;

    assign raw_s = {btn_down_raw, btn_up_raw};

    // Two-flop synchroniser for both raw buttons.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_r <= 2'b00;
            sync2_r <= 2'b00;
        end else begin
            sync1_r <= raw_s;
            sync2_r <= sync1_r;
        end
    end

    // Debounce: stable flips once sync2 has disagreed with it for DEBOUNCE_CYCLES cycles in a row.
    always_comb begin
        stable_next_s = stable_r;
        for (int c = 0; c < 2; c++) begin
            db_cnt_next_s[c] = '0;
            if (sync2_r[c] != stable_r[c]) begin
                if (db_cnt_r[c] == DB_LAST) begin
                    stable_next_s[c] = ~stable_r[c];
                    db_cnt_next_s[c] = '0;
                end else begin
                    db_cnt_next_s[c] = db_cnt_r[c] + CNT_W'(1);
                end
            end else begin
                db_cnt_next_s[c] = '0;
            end
        end
    end

    // Debounce state registers; stable doubles as the level output register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stable_r <= 2'b00;
            for (int c = 0; c < 2; c++) begin
                db_cnt_r[c] <= '0;
            end
        end else begin
            stable_r <= stable_next_s;
            for (int c = 0; c < 2; c++) begin
                db_cnt_r[c] <= db_cnt_next_s[c];
            end
        end
    end

    // The FSM reacts to the level being written this edge, so the first pulse lines up with the level change.
    assign conflict_s = stable_next_s[0] & stable_next_s[1];

    // Per-channel press/repeat FSM; the timer counts down to zero and is reloaded on every pulse.
    always_comb begin
        pulse_s = 2'b00;
        for (int c = 0; c < 2; c++) begin
            state_next_s[c] = state_r[c];
            timer_next_s[c] = timer_r[c];
            if (conflict_s) begin
                state_next_s[c] = ST_LOCKED;
                timer_next_s[c] = 32'd0;
            end else begin
                case (state_r[c])
                    ST_IDLE: begin
                        if (stable_next_s[c] && !stable_r[c]) begin
                            pulse_s[c]      = 1'b1;
                            timer_next_s[c] = HOLD_LOAD;
                            state_next_s[c] = ST_PRESSED;
                        end else begin
                            timer_next_s[c] = 32'd0;
                        end
                    end
                    ST_PRESSED, ST_REPEAT: begin
                        if (!stable_next_s[c]) begin
                            state_next_s[c] = ST_IDLE;
                            timer_next_s[c] = 32'd0;
                        end else if (timer_r[c] == 32'd0) begin
                            pulse_s[c]      = 1'b1;
                            timer_next_s[c] = REPEAT_LOAD;
                            state_next_s[c] = ST_REPEAT;
                        end else begin
                            timer_next_s[c] = timer_r[c] - 32'd1;
                        end
                    end
                    ST_LOCKED: begin
                        timer_next_s[c] = 32'd0;
                        if (!stable_next_s[c]) begin
                            state_next_s[c] = ST_IDLE;
                        end else begin
                            state_next_s[c] = ST_LOCKED;
                        end
                    end
                    default: begin
                        state_next_s[c] = ST_IDLE;
                        timer_next_s[c] = 32'd0;
                    end
                endcase
            end
        end
    end

    // FSM state, timers and registered pulse/conflict outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < 2; c++) begin
                state_r[c] <= ST_IDLE;
                timer_r[c] <= 32'd0;
            end
            gear_up_r   <= 1'b0;
            gear_down_r <= 1'b0;
            conflict_r  <= 1'b0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                state_r[c] <= state_next_s[c];
                timer_r[c] <= timer_next_s[c];
            end
            gear_up_r   <= pulse_s[0] & ~pulse_s[1];
            gear_down_r <= pulse_s[1] & ~pulse_s[0];
            conflict_r  <= (state_next_s[0] == ST_LOCKED) && (state_next_s[1] == ST_LOCKED);
        end
    end

    assign gear_up    = gear_up_r;
    assign gear_down  = gear_down_r;
    assign up_level   = stable_r[0];
    assign down_level = stable_r[1];
    assign conflict   = conflict_r;

endmodule

// File: doc/gear_button_conditioner.md
Name: gear_button_conditioner

Overview:
Upstream front end for the gear selector. It takes the two raw, bouncing push-button inputs (up and down) and produces clean single-cycle gear_up and gear_down pulses that drive the gear selector's gear_up/gear_down inputs. Each channel is synchronised and debounced. A held button auto-repeats. Simultaneous up+down presses are suppressed.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive clk cycles the synchronised input must differ from the debounced state before that state flips (10 ms at 50 MHz); minimum 1.
HOLD_CYCLES, 25000000, clk cycles from the first pulse of a held press to the first auto-repeat pulse; minimum 2.
REPEAT_CYCLES, 10000000, clk cycles between successive auto-repeat pulses; minimum 2.

Ports:
clk  input  1  system clock; all logic on the rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset).
btn_up_raw  input  1  raw gear-up push-button, active-high, asynchronous, bouncing.
btn_down_raw  input  1  raw gear-down push-button, active-high, asynchronous, bouncing.
gear_up  output  1  one-clk-wide gear-up request pulse.
gear_down  output  1  one-clk-wide gear-down request pulse.
up_level  output  1  debounced level of the up button.
down_level  output  1  debounced level of the down button.
conflict  output  1  high while both channels are in LOCKED.

Behaviour:
- Reset (reset=0) clears all state asynchronously, independent of clk. During reset, all outputs are 0, sync flops are 0, debounce counters are 0, timers are 0 and both FSMs are in IDLE.
- Synchroniser: each raw input passes through a 2-flop synchroniser (sync2 = second stage).
- Debounce, per channel:
  - Counter increments on every cycle where sync2 != stable.
  - Counter clears on any cycle where sync2 == stable.
  - When the counter would reach DEBOUNCE_CYCLES, stable toggles and the counter clears.
  - up_level and down_level are registered copies of stable.
- Latency: a clean raw edge set up before rising edge k changes stable at edge k+1+DEBOUNCE_CYCLES. The first gear pulse is high in the cycle following that edge, i.e. DEBOUNCE_CYCLES+2 clks after the raw change.
- A raw pulse or glitch shorter than DEBOUNCE_CYCLES synchronised cycles produces no level change and no pulse.
- Per-channel FSM, states IDLE, PRESSED, REPEAT, LOCKED; 32-bit timer:
  - IDLE, stable rises, other channel not asserting: emit pulse, load timer, go to PRESSED.
  - PRESSED: timer counts; after HOLD_CYCLES emit pulse, reload, go to REPEAT.
  - REPEAT: emit pulse every REPEAT_CYCLES.
  - PRESSED/REPEAT, stable falls: go to IDLE with no pulse; timer cleared.
  - LOCKED: no pulses; go to IDLE only when the channel's own stable falls.
- Conflict: whenever both stable levels are 1 in the same cycle, both FSMs go to LOCKED that cycle and every pulse scheduled in that cycle is suppressed. This covers:
  - simultaneous rise;
  - a second button rising while the first is in PRESSED or REPEAT.
  After one button is released, the other stays in LOCKED until its own release, then needs a fresh press.
- gear_up and gear_down are never high in the same cycle. Each pulse is exactly 1 clk wide.
- Pulses are registered outputs, with no combinational path from the inputs.
- Button held through reset release: after the debounce latency this is treated as a new press and emits a first pulse.
- Timers wrap only by reload, never by overflow.

Test Plan:
All cases use DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=8, and a 10 ns clk.
- Reset: hold reset=0 for 2 cycles with buttons at 0 -> all outputs 0. Assert reset=0 asynchronously mid-cycle -> outputs drop without waiting for a clk edge.
- Clean press: btn_up_raw=1 held for 10 cycles -> exactly one gear_up pulse, 6 clks after the raw rise; up_level=1; gear_down and conflict stay 0. Release -> up_level falls 6 clks later with no pulse.
- Bounce: btn_up_raw toggles 1,0,1,0,1 at 1-cycle spacing, then holds at 1 -> exactly one gear_up pulse, 6 clks after the final rise. A separate isolated 3-cycle high glitch -> no pulse and up_level stays 0.
- Auto-repeat: btn_down_raw held for 50 cycles -> gear_down pulses at offsets 0, 20, 28, 36 and 44 from the first pulse (5 pulses total). No pulse after down_level falls.
- Conflict: up held; down pressed 10 cycles later ->
  - conflict=1 from the cycle down_level rises; no gear_down pulse; up auto-repeat suppressed.
  - Release down while up is still held -> still no pulses.
  - Release up, then re-press up -> normal single pulse.
- Reset mid-repeat: during up auto-repeat, pulse reset=0 for 1 cycle with btn_up_raw still 1 -> outputs go to 0 immediately. After release, one gear_up pulse 6 clks later, then repeats at +20 and +28.
